// File: rtl/dispatch_steer_ctrl.sv
// Dispatch steering between Rename and the three issue queues: credit-aware
// all-or-nothing group dispatch with a combinational stall back to Rename.
module dispatch_steer_ctrl #(
    parameter int WIDTH_UOPS = 4,
    parameter int IQ_DEPTH   = 8,
    parameter int CW         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IN_en,
    input  logic [WIDTH_UOPS-1:0]   IN_valid,
    input  logic [4*WIDTH_UOPS-1:0] IN_fu,
    input  logic                    IN_branchTaken,
    input  logic                    IN_flushAll,
    input  logic [8:0]              IN_iqFree,
    output logic                    OUT_stall,
    output logic [WIDTH_UOPS-1:0]   OUT_valid,
    output logic [2*WIDTH_UOPS-1:0] OUT_iq,
    output logic [3*CW-1:0]         OUT_credits
);
    localparam logic [CW-1:0] DEPTH   = CW'(IQ_DEPTH);
    localparam logic [CW:0]   DEPTH_X = (CW+1)'(IQ_DEPTH);

    logic [CW-1:0]           cred   [3];
    logic [CW-1:0]           demand [3];
    logic [CW:0]             credSum[3];
    logic [2:0]              ovf;
    logic                    toggle;
    logic                    tEnd;
    logic [2*WIDTH_UOPS-1:0] target;
    logic                    anyFail;
    logic                    fire;

    // Slots are walked oldest first; demand holds credits already claimed
    // by older slots of the same group, so availability is cred > demand.
    always_comb begin : steer
        logic [1:0] q;
        logic [1:0] p;
        logic [1:0] np;
        logic       ok;
        for (int k = 0; k < 3; k++) demand[k] = '0;
        tEnd    = toggle;
        target  = '1;
        anyFail = 1'b0;
        for (int i = 0; i < WIDTH_UOPS; i++) begin
            q  = 2'd3;
            ok = 1'b1;
            p  = {1'b0, tEnd};
            np = {1'b0, ~tEnd};
            if (IN_valid[i]) begin
                case (IN_fu[4*i +: 4])
                    4'd0: begin
                        if (cred[p] > demand[p])        q = p;
                        else if (cred[np] > demand[np]) q = np;
                        else                            ok = 1'b0;
                        if (ok) tEnd = ~tEnd;
                    end
                    4'd3, 4'd6, 4'd7: q = 2'd0;
                    4'd4, 4'd5:       q = 2'd1;
                    4'd1, 4'd2:       q = 2'd2;
                    default:          q = 2'd3;
                endcase
                if (q != 2'd3) begin
                    if (cred[q] > demand[q]) demand[q] = demand[q] + 1'b1;
                    else                     ok = 1'b0;
                end
                if (!ok) anyFail = 1'b1;
            end
            target[2*i +: 2] = q;
        end
    end

    assign OUT_stall = IN_en && !IN_branchTaken && !rst && anyFail;
    assign fire      = IN_en && !IN_branchTaken && !rst && !anyFail;

    // Frees of this cycle only land in next cycle's credits.
    always_comb begin
        for (int q = 0; q < 3; q++) begin
            credSum[q] = {1'b0, cred[q]} - (fire ? {1'b0, demand[q]} : '0)
                       + (CW+1)'(IN_iqFree[3*q +: 3]);
            ovf[q]     = credSum[q] > DEPTH_X;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || IN_flushAll) begin
            for (int q = 0; q < 3; q++) cred[q] <= DEPTH;
        end else begin
            for (int q = 0; q < 3; q++) cred[q] <= ovf[q] ? DEPTH : credSum[q][CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            OUT_valid <= '0;
            OUT_iq    <= '1;
            toggle    <= 1'b0;
        end else if (IN_flushAll) begin
            OUT_valid <= '0;
            toggle    <= 1'b0;
        end else if (fire) begin
            OUT_valid <= IN_valid;
            OUT_iq    <= target;
            toggle    <= tEnd;
        end else begin
            OUT_valid <= '0;
        end
    end

    always_comb begin
        OUT_credits = '0;
        for (int q = 0; q < 3; q++) OUT_credits[q*CW +: CW] = cred[q];
    end

    // An IQ returning more entries than it holds means a credit leak upstream.
    always @(posedge clk) begin
        if (!rst && !IN_flushAll)
            assert (ovf == 3'b000) else $warning("dispatch_steer_ctrl: credit overflow, iq mask %b", ovf);
    end
endmodule

// File: doc/dispatch_steer_ctrl.md
Name: dispatch_steer_ctrl

Overview:
- Dispatch scheduler between Rename and the issue queues (IQs).
- Steers each renamed uop of a group to one of three IQs (IQ0/IQ1 = integer pair, IQ2 = memory) and tracks per-IQ free-entry credits.
- Dispatches a group all-or-nothing and raises a combinational stall back to Rename when credits are short.
- Replaces the free-running ordering bit with credit-aware steering.

Parameters:
WIDTH_UOPS, 4, uops per dispatch group
IQ_DEPTH, 8, entries per IQ; credit counter reset value
CW, 4, credit counter width; IQ_DEPTH must be <= 2^CW-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
IN_en  in  1  dispatch enable
IN_valid  in  WIDTH_UOPS x 1  uop valid, slot 0 oldest
IN_fu  in  WIDTH_UOPS x 4  FU code: 0 INT, 1 LSU, 2 ST, 3 MUL, 4 DIV, 5 FPU, 6 FMUL, 7 FDIV, 8 RN; others are treated as RN
IN_branchTaken  in  1  mispredict: squash this cycle's dispatch
IN_flushAll  in  1  full pipeline flush; all IQs are empty
IN_iqFree  in  3 x 3  entries freed by IQ q this cycle (issue or squash)
OUT_stall  out  1  group cannot dispatch this cycle (combinational)
OUT_valid  out  WIDTH_UOPS x 1  registered dispatch valid
OUT_iq  out  WIDTH_UOPS x 2  registered target IQ; 3 = no queue (RN)
OUT_credits  out  3 x CW  current credit counters (visibility/assertions)

Behaviour:
- State:
  - cred[0..2], reset IQ_DEPTH.
  - toggle bit, reset 0.
  - OUT_valid, reset all 0.
  - OUT_iq, reset all 3.
- Steering is combinational and walks slots 0..W-1 in order, keeping running demand d[q] (starts 0) and a running toggle t (starts at the toggle register):
  - INT: preferred queue p = t.
    - Target = p if cred[p] - d[p] > 0.
    - Else target = !p if cred[!p] - d[!p] > 0.
    - Else the slot fails.
    - On success t flips.
  - MUL, FMUL, FDIV -> IQ0. DIV, FPU -> IQ1. t is unchanged for these.
  - LSU, ST -> IQ2.
  - RN/other -> target 3. Consumes no credit and never fails.
  - A slot targeting q fails if cred[q] - d[q] == 0. On success d[q] increments.
  - Invalid slots are skipped and do not affect t.
- OUT_stall = IN_en && !IN_branchTaken && !rst && (any valid slot fails).
  - Frees arriving this cycle do not count toward this cycle's decision.
- Fire = IN_en && !OUT_stall && !IN_branchTaken && !rst.
- Registered outputs, 1-cycle latency:
  - On fire: OUT_valid[i] <= IN_valid[i]; OUT_iq[i] <= target; toggle <= final t.
  - Otherwise: OUT_valid <= 0. OUT_iq and toggle hold.
- Credit update every non-reset cycle: cred[q] <= cred[q] - (fire ? d[q] : 0) + IN_iqFree[q].
  - Computed at CW+1 bits.
  - Result > IQ_DEPTH is an overflow error: assertion fires, value clamps to IQ_DEPTH.
- IN_flushAll:
  - cred[q] <= IQ_DEPTH and OUT_valid <= 0, regardless of IN_iqFree or fire.
  - toggle <= 0.
  - Priority: rst > flushAll > branchTaken > fire.
- IN_branchTaken without flushAll:
  - No dispatch, OUT_valid <= 0.
  - Frees are still applied; the IQs return squashed entries via IN_iqFree in the same or later cycles.
- Stall is all-or-nothing: no partial groups, and no credits are consumed when stalled.
- Reset mid-operation discards any pending group. Rename re-presents the group after reset.
- Zero valid slots with IN_en=1: fire with all OUT_valid=0, no credit change apart from frees.

Test Plan:
- Reset, then a group of 4x INT -> OUT_stall=0; next cycle OUT_iq={0,1,0,1}, OUT_valid=1111, cred={6,6,8}, toggle=0.
- cred[0]=0 and cred[1]=3, group of 4x INT -> targets {1,1,1,fail} -> OUT_stall=1, OUT_valid=0 next cycle, credits unchanged.
- cred[2]=2, group {LSU, ST, RN, LSU} -> stall. Then IN_iqFree[2]=1 for one cycle -> cred[2]=3; re-presented group fires with OUT_iq={2,2,3,2} and cred[2]=0.
- Fire of 2x MUL in the same cycle as IN_iqFree[0]=3, starting from cred[0]=4 -> cred[0]=5; OUT_iq={0,0}.
- IN_branchTaken with a valid group and IN_iqFree[1]=2 -> OUT_valid=0 next cycle and cred[1] increases by 2. IN_flushAll with cred={1,2,3} -> cred={8,8,8} and toggle=0.
- Overflow: with cred[0]=8, IN_iqFree[0]=1 -> assertion fires and cred[0] stays 8. Assert rst during a stalled cycle -> all outputs return to their reset values the next cycle.
